// File: rtl/sd_fifo_param.sv
// Parametrised single-clock FIFO between the SD bus-side (Wishbone/DMA) and the data serialiser.
// Configurable width/depth, watermarks, level/free counts, FWFT or registered read, flush and sticky error flags.
module sd_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    input  logic              wr,
    output logic              full,
    output logic              almost_full,
    output logic [DATA_W-1:0] q,
    input  logic              rd,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W:0]   free,
    output logic              ovf,
    output logic              udf
);

    localparam int             DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_THRESH);

    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W:0]   wp;
    logic [ADDR_W:0]   rp;
    logic              we;
    logic              re;

    // Status is purely combinational from the registered pointers; the extra
    // wrap bit distinguishes full from empty when the RAM addresses coincide.
    assign level        = wp - rp;
    assign free         = DEPTH_L - level;
    assign full         = (level == DEPTH_L);
    assign empty        = (wp == rp);
    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);

    // Flush overrides both requests in the same cycle.
    assign we = wr & ~full  & ~clr;
    assign re = rd & ~empty & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (clr) begin
            wp  <= '0;
            rp  <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (we)
                wp <= wp + 1'b1;
            if (re)
                rp <= rp + 1'b1;
            if (wr && full)
                ovf <= 1'b1;
            if (rd && empty)
                udf <= 1'b1;
        end
    end

    // Storage is not reset or flushed; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (we)
            ram[wp[ADDR_W-1:0]] <= d;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign q = ram[rp[ADDR_W-1:0]];
        end else begin : g_reg
            logic [DATA_W-1:0] q_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    q_r <= '0;
                else if (re)
                    q_r <= ram[rp[ADDR_W-1:0]];
            end

            assign q = q_r;
        end
    endgenerate

endmodule
